// File: rtl/bt_pkg.sv
// Shared constants for the Bluetooth command receiver: frame format, FSM encoding, baud range.
package bt_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         MAX_LEN   = 8;
    localparam logic [2:0] BAUD_MAX  = 3'd4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GET_LEN = 2'd1;
    localparam logic [1:0] ST_GET_PAY = 2'd2;
    localparam logic [1:0] ST_GET_CHK = 2'd3;

    function automatic logic [2:0] next_baud(input logic [2:0] b);
        return (b == BAUD_MAX) ? 3'd0 : b + 3'd1;
    endfunction
endpackage

// File: rtl/bluetooth_rx_ctrl_if.sv
// Byte-stream input, control and command-output bundle of the Bluetooth receive controller.
interface bluetooth_rx_ctrl_if;
    logic [7:0]  rx_byte;
    logic        rx_done;
    logic        hunt_en;
    logic        lock_clr;
    logic [2:0]  baud_set;
    logic        baud_locked;
    logic        cmd_valid;
    logic [3:0]  cmd_len;
    logic [63:0] cmd_data;
    logic        frame_err;

    modport master (
        output rx_byte, rx_done, hunt_en, lock_clr,
        input  baud_set, baud_locked, cmd_valid, cmd_len, cmd_data, frame_err
    );
    modport slave (
        input  rx_byte, rx_done, hunt_en, lock_clr,
        output baud_set, baud_locked, cmd_valid, cmd_len, cmd_data, frame_err
    );
endinterface

// File: rtl/bt_baud_hunter.sv
// Baud-rate hunt: counts frame errors while unlocked and steps baud_set 0..4 after ERR_LIMIT of them.
module bt_baud_hunter
    import bt_pkg::*;
#(
    parameter int ERR_LIMIT = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       hunt_en,
    input  logic       lock_clr,
    input  logic       frame_err,
    input  logic       frame_ok,
    output logic [2:0] baud_set,
    output logic       baud_locked,
    output logic       hunt_go
);
    localparam int CW = $clog2(ERR_LIMIT + 1);

    logic [CW-1:0] err_cnt;

    // Count saturates at the limit so a frozen hunt resumes stepping as soon as hunt_en returns.
    assign hunt_go = hunt_en && !baud_locked && (err_cnt == CW'(ERR_LIMIT));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_cnt     <= '0;
            baud_set    <= '0;
            baud_locked <= 1'b0;
        end else if (frame_ok) begin
            baud_locked <= 1'b1;
            err_cnt     <= '0;
        end else if (lock_clr) begin
            baud_locked <= 1'b0;
            err_cnt     <= '0;
        end else if (hunt_go) begin
            baud_set <= next_baud(baud_set);
            err_cnt  <= '0;
        end else if (frame_err && !baud_locked && err_cnt != CW'(ERR_LIMIT)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/bluetooth_rx_ctrl.sv
// Frame parser (SYNC, LEN, payload, XOR checksum) with inter-byte timeout, driving the baud hunter.
module bluetooth_rx_ctrl
    import bt_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int ERR_LIMIT   = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    bluetooth_rx_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int IW = $clog2(MAX_LEN);

    logic [1:0]                  state, nstate;
    logic [TW-1:0]               timer;
    logic [3:0]                  len;
    logic [IW-1:0]               idx;
    logic [7:0]                  chk;
    logic [MAX_LEN-1:0][7:0]     pay_buf;
    logic                        timeout, frame_ok, frame_bad, hunt_go, force_idle;

    assign timeout = (state != ST_IDLE) && !bus.rx_done && (timer == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        nstate    = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (timeout) begin
            frame_bad = 1'b1;
            nstate    = ST_IDLE;
        end else if (bus.rx_done) begin
            case (state)
                ST_IDLE:
                    if (bus.rx_byte == SYNC_BYTE) nstate = ST_GET_LEN;
                ST_GET_LEN:
                    if (bus.rx_byte >= 8'd1 && bus.rx_byte <= 8'(MAX_LEN)) nstate = ST_GET_PAY;
                    else begin
                        frame_bad = 1'b1;
                        nstate    = ST_IDLE;
                    end
                ST_GET_PAY:
                    if ({1'b0, idx} == len - 4'd1) nstate = ST_GET_CHK;
                default: begin
                    if (bus.rx_byte == chk) frame_ok  = 1'b1;
                    else                    frame_bad = 1'b1;
                    nstate = ST_IDLE;
                end
            endcase
        end
        // A completing valid frame takes priority over lock_clr.
        force_idle = hunt_go || (bus.lock_clr && !frame_ok);
        if (force_idle) nstate = ST_IDLE;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= ST_IDLE;
            timer         <= '0;
            len           <= '0;
            idx           <= '0;
            chk           <= '0;
            pay_buf       <= '0;
            bus.cmd_valid <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.cmd_len   <= '0;
            bus.cmd_data  <= '0;
        end else begin
            state         <= nstate;
            bus.cmd_valid <= frame_ok;
            bus.frame_err <= frame_bad;
            timer         <= (state == ST_IDLE || bus.rx_done || timeout) ? '0 : timer + 1'b1;
            if (bus.rx_done) begin
                case (state)
                    ST_GET_LEN: begin
                        len     <= bus.rx_byte[3:0];
                        chk     <= bus.rx_byte;
                        idx     <= '0;
                        pay_buf <= '0;
                    end
                    ST_GET_PAY: begin
                        pay_buf[idx] <= bus.rx_byte;
                        chk          <= chk ^ bus.rx_byte;
                        idx          <= idx + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (frame_ok) begin
                bus.cmd_len  <= len;
                bus.cmd_data <= pay_buf;
            end
        end
    end

    bt_baud_hunter #(.ERR_LIMIT(ERR_LIMIT)) u_hunter (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .hunt_en     (bus.hunt_en),
        .lock_clr    (bus.lock_clr),
        .frame_err   (frame_bad),
        .frame_ok    (frame_ok),
        .baud_set    (bus.baud_set),
        .baud_locked (bus.baud_locked),
        .hunt_go     (hunt_go)
    );
endmodule
